scr1_cg_ctrl: RTL and testbench
===============================

// Module: scr1_cg_ctrl
// PURPOSE
//   Clock-gate enable controller driving the clk_en input of the core clock gate cell.
//   Watches core idle status, negotiates quiescence with the core via req/ack, deasserts clk_en
//   when safe, and restores the clock on wake-up with a fixed settle delay before releasing the core.
//   Runs on the free-running (ungated) clock; sits beside the clock gate in the clock-control block.
// PARAMETERS
//   IDLE_THRESH  16  consecutive idle cycles required before gating is requested (>=1)
//   WAKE_DLY     2   cycles clk_en is high before core_rdy asserts (>=1)
//   CNT_W        16  width of gate_events saturating counter
// PORTS
//   clk          in   1      free-running clock (never gated)
//   rst          in   1      synchronous reset, active-high
//   cfg_gate_en  in   1      software enable of clock gating; 0 = clock always on
//   core_idle    in   1      core in WFI / no work pending
//   wake_req     in   1      wake-up source (IRQ pending | debug request), level
//   gate_ack     in   1      core quiesced, safe to stop clock; level, held while gated
//   gate_req     out  1      request to core to quiesce before gating
//   clk_en       out  1      enable to clock gate cell; 1 = core clock runs
//   core_rdy     out  1      core clock stable, core may resume issue
//   gate_events  out  CNT_W  number of entries into GATED, saturating at all-ones
// BEHAVIOUR
//   Reset: state=RUN, clk_en=1, core_rdy=1, gate_req=0, gate_events=0, idle counter=0.
//   All outputs registered; no combinational input->output paths.
//   States:
//   - RUN: clk_en=1, core_rdy=1. Idle counter increments each cycle with core_idle & cfg_gate_en
//     & ~wake_req, else clears to 0. When counter reaches IDLE_THRESH-1 with those conditions
//     still true -> REQ (gate_req=1 next cycle). Counter saturates, never wraps.
//   - REQ: gate_req=1, clk_en=1, core_rdy=1. wake_req | ~core_idle | ~cfg_gate_en -> RUN
//     (gate_req drops, counter clears). Else gate_ack=1 -> GATED. Abort beats ack on same cycle.
//   - GATED: clk_en=0, core_rdy=0, gate_req=1. gate_events += 1 on entry (saturating).
//     wake_req | ~cfg_gate_en -> WAKE. core_idle/gate_ack ignored (core unclocked).
//   - WAKE: clk_en=1, core_rdy=0, gate_req=0; counts WAKE_DLY cycles, then -> RUN
//     (core_rdy=1). wake_req deassertion during WAKE does not abort the sequence.
//   Latency: wake_req sampled high in GATED -> clk_en=1 next cycle -> core_rdy=1 WAKE_DLY cycles
//     after clk_en rises.
//   clk_en never changes in the same cycle as core_rdy rises; clk_en=0 only in GATED.
//   cfg_gate_en=0 in any state forces exit towards RUN via the paths above; never enters REQ.
//   gate_ack while not in REQ is ignored; gate_ack drop while GATED has no effect.
//   Reset mid-GATED or mid-WAKE: clk_en=1, core_rdy=1 immediately next cycle (synchronous).
//   gate_events holds at 2^CNT_W-1 once reached; cleared only by rst.
// TESTING
//   1 rst 3 cycles -> clk_en=1, core_rdy=1, gate_req=0, gate_events=0.
//   2 cfg_gate_en=1, core_idle=1 for 16 cycles -> gate_req=1 on cycle 16; gate_ack=1 ->
//     clk_en=0 next cycle, gate_events=1.
//   3 In GATED, pulse wake_req 1 cycle -> clk_en=1 next cycle, core_rdy=1 exactly 2 cycles later,
//     gate_req=0.
//   4 core_idle drops at idle count 10 -> counter clears, no gate_req; wake_req and gate_ack same
//     cycle in REQ -> back to RUN, clk_en stays 1, gate_events unchanged.
//   5 cfg_gate_en=0 with core_idle=1 for 100 cycles -> gate_req never asserts; clearing cfg_gate_en
//     while GATED -> WAKE, core_rdy=1 after 2 cycles.
//   6 CNT_W=2: four gate/wake cycles -> gate_events 1,2,3,3; rst asserted in GATED -> clk_en=1 next.

Source files
------------

// File: rtl/scr1_cg_ctrl.sv
// Clock-gate enable controller: idle detection, req/ack quiescence handshake with the core,
// clock stop and timed wake-up. Runs on the free-running clock; all outputs are registered.
module scr1_cg_ctrl #(
  parameter int IDLE_THRESH = 16,
  parameter int WAKE_DLY    = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_gate_en,
  input  logic             core_idle,
  input  logic             wake_req,
  input  logic             gate_ack,
  output logic             gate_req,
  output logic             clk_en,
  output logic             core_rdy,
  output logic [CNT_W-1:0] gate_events
);

  localparam int IW = (IDLE_THRESH > 1) ? $clog2(IDLE_THRESH) : 1;
  localparam int WW = (WAKE_DLY > 1) ? $clog2(WAKE_DLY) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_THRESH - 1);
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_DLY - 1);

  typedef enum logic [1:0] {RUN, REQ, GATED, WAKE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idle_cnt, idle_cnt_nxt;
  logic [WW-1:0]   wake_cnt, wake_cnt_nxt;
  logic            gate_ok;
  logic            enter_gated;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign gate_ok = core_idle & cfg_gate_en & ~wake_req;

  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = '0;
    wake_cnt_nxt = '0;
    enter_gated  = 1'b0;
    case (state)
      RUN: begin
        if (gate_ok) begin
          if (idle_cnt == IDLE_LAST) state_nxt = REQ;
          else                       idle_cnt_nxt = idle_cnt + IW'(1);
        end
      end
      REQ: begin
        // An abort condition wins over an ack arriving in the same cycle.
        if (wake_req | ~core_idle | ~cfg_gate_en) begin
          state_nxt = RUN;
        end else if (gate_ack) begin
          state_nxt   = GATED;
          enter_gated = 1'b1;
        end
      end
      GATED: begin
        if (wake_req | ~cfg_gate_en) state_nxt = WAKE;
      end
      WAKE: begin
        if (wake_cnt == WAKE_LAST) state_nxt = RUN;
        else                       wake_cnt_nxt = wake_cnt + WW'(1);
      end
      default: state_nxt = RUN;
    endcase
  end

  // Outputs are registered from the next state so they change together with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      idle_cnt    <= '0;
      wake_cnt    <= '0;
      clk_en      <= 1'b1;
      core_rdy    <= 1'b1;
      gate_req    <= 1'b0;
      gate_events <= '0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_cnt_nxt;
      wake_cnt <= wake_cnt_nxt;
      clk_en   <= (state_nxt != GATED);
      core_rdy <= (state_nxt == RUN) || (state_nxt == REQ);
      gate_req <= (state_nxt == REQ) || (state_nxt == GATED);
      if (enter_gated) gate_events <= sat_inc(gate_events);
    end
  end

endmodule

// File: tb/tb_scr1_cg_ctrl.sv
// Bench for scr1_cg_ctrl: a default-parameter instance driven from a vector table, and a
// small-counter instance exercised by hand-written gate/wake sequences.
module tb_scr1_cg_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, cfg, idle, wake, ack;
  logic req0, clk_en0, rdy0;
  logic [15:0] ev0;

  logic rst1, cfg1, idle1, wake1, ack1;
  logic req1, clk_en1, rdy1;
  logic [1:0] ev1;

  scr1_cg_ctrl #(.IDLE_THRESH(16), .WAKE_DLY(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cfg_gate_en(cfg), .core_idle(idle), .wake_req(wake),
    .gate_ack(ack), .gate_req(req0), .clk_en(clk_en0), .core_rdy(rdy0), .gate_events(ev0)
  );

  scr1_cg_ctrl #(.IDLE_THRESH(2), .WAKE_DLY(1), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst1), .cfg_gate_en(cfg1), .core_idle(idle1), .wake_req(wake1),
    .gate_ack(ack1), .gate_req(req1), .clk_en(clk_en1), .core_rdy(rdy1), .gate_events(ev1)
  );

  typedef struct {
    logic rst, cfg, idle, wake, ack;
    int   rep;
    logic e_clk, e_rdy, e_req;
    logic [15:0] e_ev;
  } vec_t;

  typedef struct {
    logic e_clk, e_rdy, e_req;
    logic [15:0] e_ev;
    string name;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(input logic r, c, i, w, a, input int n,
                              input logic ec, er, eq, input logic [15:0] ee);
    vec_t v;
    v.rst = r; v.cfg = c; v.idle = i; v.wake = w; v.ack = a; v.rep = n;
    v.e_clk = ec; v.e_rdy = er; v.e_req = eq; v.e_ev = ee;
    return v;
  endfunction

  function automatic exp_t mkexp(input logic ec, er, eq, input logic [15:0] ee, input string nm);
    exp_t e;
    e.e_clk = ec; e.e_rdy = er; e.e_req = eq; e.e_ev = ee; e.name = nm;
    return e;
  endfunction

  task automatic check(input bit sel);
    exp_t e;
    logic a_clk, a_rdy, a_req;
    logic [15:0] a_ev;
    e = sbq.pop_front();
    if (sel) begin a_clk = clk_en1; a_rdy = rdy1; a_req = req1; a_ev = {14'd0, ev1}; end
    else     begin a_clk = clk_en0; a_rdy = rdy0; a_req = req0; a_ev = ev0; end
    n_vec++;
    if (a_clk !== e.e_clk || a_rdy !== e.e_rdy || a_req !== e.e_req || a_ev !== e.e_ev) begin
      n_err++;
      $display("FAIL %s: got clk_en=%b core_rdy=%b gate_req=%b gate_events=%0d, want clk_en=%b core_rdy=%b gate_req=%b gate_events=%0d",
               e.name, a_clk, a_rdy, a_req, a_ev, e.e_clk, e.e_rdy, e.e_req, e.e_ev);
    end
  endtask

  task automatic apply(input bit sel, input logic r, c, i, w, a, input exp_t e);
    if (sel) begin rst1 = r; cfg1 = c; idle1 = i; wake1 = w; ack1 = a; end
    else     begin rst  = r; cfg  = c; idle  = i; wake  = w; ack  = a; end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    check(sel);
  endtask

  logic [15:0] ev_exp[4];
  logic [15:0] prev;

  initial begin
    rst = 1'b1; cfg = 1'b0; idle = 1'b0; wake = 1'b0; ack = 1'b0;
    rst1 = 1'b1; cfg1 = 1'b0; idle1 = 1'b0; wake1 = 1'b0; ack1 = 1'b0;

    //             rst cfg idl wak ack rep  clk rdy req ev
    vecs.push_back(mk(1, 0, 0, 0, 0,   3,  1, 1, 0, 0));  // reset state
    vecs.push_back(mk(0, 1, 1, 0, 0,  15,  1, 1, 0, 0));  // idle count 1..15
    vecs.push_back(mk(0, 1, 1, 0, 0,   1,  1, 1, 1, 0));  // 16th idle cycle -> REQ
    vecs.push_back(mk(0, 1, 1, 0, 0,   2,  1, 1, 1, 0));  // wait for ack
    vecs.push_back(mk(0, 1, 1, 0, 1,   1,  0, 0, 1, 1));  // GATED
    vecs.push_back(mk(0, 1, 0, 0, 0,   3,  0, 0, 1, 1));  // idle/ack ignored while gated
    vecs.push_back(mk(0, 1, 0, 1, 0,   1,  1, 0, 0, 1));  // wake pulse -> WAKE
    vecs.push_back(mk(0, 1, 0, 0, 0,   1,  1, 0, 0, 1));  // settle cycle
    vecs.push_back(mk(0, 1, 0, 0, 0,   1,  1, 1, 0, 1));  // core_rdy back
    vecs.push_back(mk(0, 1, 1, 0, 0,  10,  1, 1, 0, 1));  // count to 10
    vecs.push_back(mk(0, 1, 0, 0, 0,   1,  1, 1, 0, 1));  // idle drop clears
    vecs.push_back(mk(0, 1, 1, 0, 0,  15,  1, 1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0,   1,  1, 1, 1, 1));  // REQ again after full 16
    vecs.push_back(mk(0, 1, 1, 1, 1,   1,  1, 1, 0, 1));  // wake beats ack
    vecs.push_back(mk(0, 1, 1, 1, 0,  20,  1, 1, 0, 1));  // wake blocks counting
    vecs.push_back(mk(0, 1, 1, 0, 0,  15,  1, 1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0,   1,  1, 1, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 1,   1,  1, 1, 0, 1));  // idle drop beats ack
    vecs.push_back(mk(0, 1, 1, 0, 0,  15,  1, 1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0,   1,  1, 1, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1,   1,  1, 1, 0, 1));  // cfg drop beats ack
    vecs.push_back(mk(0, 0, 1, 0, 0, 100,  1, 1, 0, 1));  // gating disabled
    vecs.push_back(mk(0, 1, 1, 0, 0,  15,  1, 1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0,   1,  1, 1, 1, 1));
    vecs.push_back(mk(0, 1, 1, 0, 1,   1,  0, 0, 1, 2));
    vecs.push_back(mk(0, 0, 1, 0, 1,   1,  1, 0, 0, 2));  // cfg cleared while gated
    vecs.push_back(mk(0, 0, 1, 0, 0,   1,  1, 0, 0, 2));
    vecs.push_back(mk(0, 0, 1, 0, 0,   1,  1, 1, 0, 2));
    vecs.push_back(mk(0, 1, 0, 0, 1,   5,  1, 1, 0, 2));  // stray ack in RUN
    vecs.push_back(mk(0, 1, 1, 0, 0,  15,  1, 1, 0, 2));
    vecs.push_back(mk(0, 1, 1, 0, 0,   1,  1, 1, 1, 2));
    vecs.push_back(mk(0, 1, 1, 0, 1,   1,  0, 0, 1, 3));
    vecs.push_back(mk(0, 1, 1, 1, 0,   1,  1, 0, 0, 3));  // into WAKE
    vecs.push_back(mk(1, 1, 1, 0, 0,   1,  1, 1, 0, 0));  // reset mid-WAKE
    vecs.push_back(mk(0, 1, 0, 0, 0,   2,  1, 1, 0, 0));

    for (int n = 0; n < vecs.size(); n++) begin
      for (int k = 0; k < vecs[n].rep; k++) begin
        apply(1'b0, vecs[n].rst, vecs[n].cfg, vecs[n].idle, vecs[n].wake, vecs[n].ack,
              mkexp(vecs[n].e_clk, vecs[n].e_rdy, vecs[n].e_req, vecs[n].e_ev,
                    $sformatf("vec%0d.%0d", n, k)));
      end
    end

    // Small instance: 2-bit event counter saturation, then reset while gated.
    ev_exp[0] = 16'd1; ev_exp[1] = 16'd2; ev_exp[2] = 16'd3; ev_exp[3] = 16'd3;
    apply(1'b1, 1, 0, 0, 0, 0, mkexp(1, 1, 0, 0, "small_rst"));
    prev = 16'd0;
    for (int g = 0; g < 4; g++) begin
      apply(1'b1, 0, 1, 1, 0, 0, mkexp(1, 1, 0, prev,      $sformatf("small%0d_idle", g)));
      apply(1'b1, 0, 1, 1, 0, 0, mkexp(1, 1, 1, prev,      $sformatf("small%0d_req", g)));
      apply(1'b1, 0, 1, 1, 0, 1, mkexp(0, 0, 1, ev_exp[g], $sformatf("small%0d_gated", g)));
      apply(1'b1, 0, 1, 0, 1, 0, mkexp(1, 0, 0, ev_exp[g], $sformatf("small%0d_wake", g)));
      apply(1'b1, 0, 1, 0, 0, 0, mkexp(1, 1, 0, ev_exp[g], $sformatf("small%0d_run", g)));
      prev = ev_exp[g];
    end
    apply(1'b1, 0, 1, 1, 0, 0, mkexp(1, 1, 0, 3, "small_idle"));
    apply(1'b1, 0, 1, 1, 0, 0, mkexp(1, 1, 1, 3, "small_req"));
    apply(1'b1, 0, 1, 1, 0, 1, mkexp(0, 0, 1, 3, "small_gated_sat"));
    apply(1'b1, 1, 1, 1, 0, 1, mkexp(1, 1, 0, 0, "small_rst_gated"));
    apply(1'b1, 0, 1, 0, 0, 0, mkexp(1, 1, 0, 0, "small_after_rst"));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
